microwave_ctrl: RTL
===================

# microwave_ctrl

Sequencing controller for the microwave timer datapath (`MS_Timer`).
- Turns keypad digit strobes into timer load pulses.
- Handles start, stop and door events through a cooking state machine.
- Prescales the system clock into one-cycle `timer_en` ticks per second and raises `mag_on` and a completion beep.
- Sits between the keypad/door front end and the timer and display.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one-second timer tick (≥2).
- `BEEP_CYCLES`, default 100_000_000: cycles `beep` stays high in DONE (≥1).
- `MAX_DIGITS`, default 3: maximum digits accepted per entry (mins, sec_tens, sec_ones).

Ports:
- `clock`  in  1  system clock, rising edge.
- `clrn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `key_valid`  in  1  one-cycle strobe, keypad digit present.
- `key_code`  in  4  digit value; only 0–9 valid.
- `start`  in  1  start/resume request (level, sampled each cycle).
- `stop`  in  1  pause/cancel request (level, sampled each cycle).
- `door_closed`  in  1  1 = door closed.
- `timer_zero`  in  1  `zero` output of the timer.
- `load_n`  out  1  timer load, active-low.
- `data`  out  4  digit to timer, valid while `load_n`=0.
- `timer_clr_n`  out  1  timer clear, active-low.
- `timer_en`  out  1  timer decrement enable, one-cycle pulse per tick.
- `mag_on`  out  1  magnetron drive.
- `beep`  out  1  completion tone.
- `state`  out  3  current state: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- All outputs are registered. Reset values are:
  - `state`=IDLE
  - `load_n`=1
  - `data`=0
  - `timer_clr_n`=0
  - `timer_en`=0
  - `mag_on`=0
  - `beep`=0
  - digit count=0
  - prescaler=0
  - beep counter=0
- `timer_clr_n` returns to 1 on the first edge after reset release.
- Digit load: in IDLE/ENTRY, `key_valid` with `key_code`≤9 and digit count<MAX_DIGITS gives `load_n`=0 and `data`=`key_code` for exactly one cycle, and increments the digit count. IDLE→ENTRY. Codes >9, or digits beyond MAX_DIGITS, are ignored.
- **IDLE:** `stop` gives a one-cycle clear. `start` is ignored.
- **ENTRY:**
  - `stop` gives a one-cycle `timer_clr_n`=0, digit count=0, →IDLE.
  - else `start`&`door_closed`&!`timer_zero` →COOK with prescaler=0.
  - `start` with door open or `timer_zero`=1 is ignored.
- **COOK:**
  - `mag_on`=1.
  - Prescaler counts 0..TICK_DIV-1; `timer_en`=1 in the cycle after it wraps.
  - Priority: `timer_zero` →DONE, then `stop` or !`door_closed` →PAUSE.
  - Keys are ignored.
- **PAUSE:**
  - `mag_on`=0, prescaler held.
  - `stop` clears the timer, →IDLE.
  - else `start`&`door_closed` →COOK, prescaler resumes from its held value.
  - Keys are ignored.
- **DONE:**
  - `beep`=1 and `mag_on`=0; the timer is cleared on entry.
  - After BEEP_CYCLES →IDLE.
  - `stop`, `key_valid` or door opening → early IDLE; that key is not loaded.
- On every return to IDLE, `beep`=0 and digit count=0.
- Widths: prescaler $clog2(TICK_DIV) bits; beep counter $clog2(BEEP_CYCLES+1) bits; no overflow is possible.

## Timing
- Key strobe sampled at edge N → `load_n`=0 in cycle N..N+1; the timer captures at edge N+1.
- Back-to-back strobes produce back-to-back load pulses.
- State change is visible one cycle after the sampling edge. `mag_on` follows `state`.
- First `timer_en` pulse occurs TICK_DIV cycles after entering COOK; pulses repeat every TICK_DIV cycles.
- `timer_en` is never high outside COOK, and never high in the cycle `timer_zero` is sampled 1.
- `stop` and `start` in the same cycle: `stop` wins in every state.
- Reset asserted mid-COOK: all outputs go to reset values immediately, asynchronously, and the timer is cleared via `timer_clr_n`=0.

## Test plan
1. **Entry and count-down.** TICK_DIV=4, BEEP_CYCLES=3. Keys 2, 9, then `start` with door closed.
   - Expect two `load_n` pulses with `data`=2 then 9; timer at 0:29.
   - Expect COOK; a `timer_en` pulse every 4 cycles.
   - After 29 pulses: DONE, `beep` high 3 cycles, then IDLE.
2. **Digit limit and invalid codes.** Keys 1, 12, 2, 3, 4.
   - Expect exactly three load pulses, with `data` 1, 2, 3; 12 and 4 are ignored.
3. **Door open mid-cook.**
   - Door opens → PAUSE next cycle, `mag_on`=0, no `timer_en`.
   - Door closes, no `start` → stays in PAUSE.
   - `start` → COOK; the tick resumes with the prescaler phase preserved.
4. **Cancel.** `stop` in ENTRY and in PAUSE.
   - Expect a one-cycle `timer_clr_n`=0 and IDLE; timer at 0:00.
   - Next digit is loaded as the first digit.
5. **Start blocked.** Start with `timer_zero`=1, or with door open.
   - Expect to remain in IDLE/ENTRY, `mag_on`=0.
   - `stop`+`start` together in PAUSE → IDLE.
6. **Reset mid-cook.** Assert `clrn`=0 asynchronously.
   - Expect all outputs at reset values, with `timer_clr_n`=0, before the next edge.
   - After release: IDLE, `timer_clr_n`=1.

Source files
------------

// File: rtl/microwave_ctrl.sv
// Cooking sequencer between keypad/door front end and the MS_Timer datapath:
// digit loads, start/stop/door FSM, one-second tick prescaler and completion beep.
module microwave_ctrl #(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned BEEP_CYCLES = 100_000_000,
   parameter int unsigned MAX_DIGITS  = 3
) (
   input  logic       clock,
   input  logic       clrn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic       load_n,
   output logic [3:0] data,
   output logic       timer_clr_n,
   output logic       timer_en,
   output logic       mag_on,
   output logic       beep,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned BW = (BEEP_CYCLES > 0) ? $clog2(BEEP_CYCLES + 1) : 1;
   localparam int unsigned DW = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);
   localparam logic [DW-1:0] DIGIT_MAX  = DW'(MAX_DIGITS);

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
   logic [DW-1:0]   digits_q, digits_d;
   logic            load_n_q, load_n_d;
   logic [3:0]      data_q, data_d;
   logic            clr_n_q, clr_n_d;
   logic            en_q, en_d;
   logic            mag_q, mag_d;
   logic            beep_q, beep_d;

   logic            key_ok;
   logic            load_go;
   logic            cook_stay;
   logic            clear_req;

   assign key_ok    = key_valid && (key_code <= 4'd9) && (digits_q < DIGIT_MAX);
   assign cook_stay = (state_q == S_COOK) && (state_d == S_COOK);
   // A digit is only taken when the FSM settles in ENTRY, so stop/start win over keys.
   assign load_go   = ((state_q == S_IDLE) || (state_q == S_ENTRY)) &&
                      (state_d == S_ENTRY) && key_ok;
   assign clear_req = (stop && ((state_q == S_IDLE) || (state_q == S_ENTRY) ||
                                (state_q == S_PAUSE))) ||
                      ((state_q == S_COOK) && (state_d == S_DONE));

   // State and output registers.
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q    <= S_IDLE;
         presc_q    <= '0;
         beep_cnt_q <= '0;
         digits_q   <= '0;
         load_n_q   <= 1'b1;
         data_q     <= 4'd0;
         clr_n_q    <= 1'b0;
         en_q       <= 1'b0;
         mag_q      <= 1'b0;
         beep_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         presc_q    <= presc_d;
         beep_cnt_q <= beep_cnt_d;
         digits_q   <= digits_d;
         load_n_q   <= load_n_d;
         data_q     <= data_d;
         clr_n_q    <= clr_n_d;
         en_q       <= en_d;
         mag_q      <= mag_d;
         beep_q     <= beep_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!stop && key_ok) state_d = S_ENTRY;
         end
         S_ENTRY: begin
            if (stop)                                        state_d = S_IDLE;
            else if (start && door_closed && !timer_zero)    state_d = S_COOK;
         end
         S_COOK: begin
            if (timer_zero)                  state_d = S_DONE;
            else if (stop || !door_closed)   state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (stop)                        state_d = S_IDLE;
            else if (start && door_closed)   state_d = S_COOK;
         end
         S_DONE: begin
            if (stop || key_valid || !door_closed || (beep_cnt_q == BEEP_LAST))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered-output and datapath next values.
   always_comb begin
      load_n_d   = ~load_go;
      data_d     = load_go ? key_code : data_q;
      clr_n_d    = ~clear_req;
      mag_d      = (state_d == S_COOK);
      beep_d     = (state_d == S_DONE);
      en_d       = cook_stay && (presc_q == PRESC_LAST);

      digits_d = digits_q;
      if (state_d == S_IDLE)  digits_d = '0;
      else if (load_go)       digits_d = digits_q + 1'b1;

      // Prescaler restarts on a fresh cook and only advances while cooking continues,
      // so a pause keeps the tick phase.
      presc_d = presc_q;
      if ((state_q == S_ENTRY) && (state_d == S_COOK))
         presc_d = '0;
      else if (cook_stay)
         presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

      beep_cnt_d = '0;
      if ((state_q == S_DONE) && (state_d == S_DONE))
         beep_cnt_d = beep_cnt_q + 1'b1;
   end

   assign state       = state_q;
   assign load_n      = load_n_q;
   assign data        = data_q;
   assign timer_clr_n = clr_n_q;
   assign timer_en    = en_q;
   assign mag_on      = mag_q;
   assign beep        = beep_q;

endmodule
